// File: rtl/toggle_handshake_rx_pkg.sv
// Shared types and constants for the toggle handshake receiver.
// The default data width is shared with the matching toggle sender.
package toggle_handshake_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Toggle request/ack pair plus the captured-word valid/ready stream.
// The slave modport is the receiver; the master is the sender/consumer side.
interface toggle_handshake_rx_if
  import toggle_handshake_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              REQ_T;
  logic [DATA_W-1:0] DATA;
  logic              ACK_T;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;

  modport slave (
    input  REQ_T,
    input  DATA,
    input  OUT_READY,
    output ACK_T,
    output OUT_DATA,
    output OUT_VALID
  );

  modport master (
    output REQ_T,
    output DATA,
    output OUT_READY,
    input  ACK_T,
    input  OUT_DATA,
    input  OUT_VALID
  );

endinterface

// File: rtl/toggle_handshake_rx_sync_bit.sv
// Single-bit multi-flop synchroniser, async active-low reset to 0.
// Reused for any toggle or level crossing into the local clock.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a 2-phase toggle handshake: detects REQ_T flips,
// captures DATA onto a valid/ready stream and returns ACK_T on accept.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  toggle_handshake_rx_if.slave hs,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             OVERRUN,
  input  logic             CLR_OVR
);

  if (SYNC_STAGES < SYNC_MIN ||
      SYNC_STAGES > SYNC_MAX) begin : g_bad
    $error("SYNC_STAGES out of range");
  end

  logic req_s;
  logic req_d;
  logic toggle_det;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (hs.REQ_T),
    .q  (req_s)
  );

  assign toggle_det = req_s ^ req_d;

  state_t            state, state_n;
  logic              ack_q, ack_n;
  logic              vld_q, vld_n;
  logic [DATA_W-1:0] dat_q, dat_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              ovr_q, ovr_n;

  always_comb begin
    state_n = state;
    ack_n   = ack_q;
    vld_n   = vld_q;
    dat_n   = dat_q;
    cnt_n   = cnt_q;
    ovr_n   = ovr_q & ~CLR_OVR;
    unique case (state)
      IDLE: begin
        if (toggle_det) begin
          dat_n   = hs.DATA;
          vld_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (hs.OUT_READY) begin
          vld_n   = 1'b0;
          ack_n   = ~ack_q;
          cnt_n   = cnt_q + CNT_W'(1);
          state_n = IDLE;
        end
        // sender flipped again before seeing ACK_T; set beats clear
        if (toggle_det) ovr_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_d <= 1'b0;
      state <= IDLE;
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      dat_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      req_d <= req_s;
      state <= state_n;
      ack_q <= ack_n;
      vld_q <= vld_n;
      dat_q <= dat_n;
      cnt_q <= cnt_n;
      ovr_q <= ovr_n;
    end
  end

  assign hs.ACK_T     = ack_q;
  assign hs.OUT_VALID = vld_q;
  assign hs.OUT_DATA  = dat_q;
  assign EVT_CNT      = cnt_q;
  assign OVERRUN      = ovr_q;

endmodule
